fpu_adder16: RTL and testbench

FPU_ADDER16 -- requirements
Module: fpu_adder16

---
 rtl/fpu_adder16_pkg.sv | 29 ++
 rtl/fpu_align16.sv | 44 ++++
 rtl/fpu_adder16.sv | 125 ++++++++++++
 tb/tb_fpu_adder16.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fpu_adder16_pkg.sv
// Shared FP16 definitions: width macros, fp16_t, and the adder stage-register struct.
`ifndef FP16_FRACW
`define FP16_FRACW 10
`endif
`ifndef FP16_EXPW
`define FP16_EXPW 5
`endif

package fpu_adder16_pkg;

    localparam int unsigned FRACW = `FP16_FRACW;
    localparam int unsigned EXPW  = `FP16_EXPW;

    // frac is the explicit significand; there is no hidden bit.
    typedef struct packed {
        logic            sign;
        logic [EXPW-1:0] exp;
        logic [FRACW-1:0] frac;
    } fp16_t;

    // Register between align (S1) and add (S2).
    typedef struct packed {
        fp16_t            l;
        logic [FRACW-1:0] s_shift;
        logic             eff_sub;
        logic             sticky;
    } fpAdd16Stage_t;

endpackage

// File: rtl/fpu_align16.sv
// S1 of the FP16 adder: apply sub to b, order operands by magnitude, align the
// smaller significand. Purely combinational. Sticky only with FPU_ADD_STICKY_EN.
module fpu_align16
    import fpu_adder16_pkg::*;
(
    input  fp16_t         a,
    input  fp16_t         b,
    input  logic          sub,
    output fpAdd16Stage_t stage
);

    fp16_t           b_eff;
    fp16_t           l;
    fp16_t           s;
    logic [EXPW-1:0] d;
`ifdef FPU_ADD_STICKY_EN
    logic [FRACW-1:0] mask;
`endif

    // Compare/swap on {exp,frac} (tie keeps a as larger), then shift the smaller.
    always_comb begin
        b_eff      = b;
        b_eff.sign = b.sign ^ sub;
        if ({a.exp, a.frac} >= {b.exp, b.frac}) begin
            l = a;
            s = b_eff;
        end else begin
            l = b_eff;
            s = a;
        end
        d = l.exp - s.exp;
        stage         = '0;
        stage.l       = l;
        stage.eff_sub = l.sign ^ s.sign;
        stage.s_shift = (d >= EXPW'(FRACW + 1)) ? '0 : (s.frac >> d);
`ifdef FPU_ADD_STICKY_EN
        mask         = (d >= EXPW'(FRACW)) ? '1 : ~({FRACW{1'b1}} << d);
        stage.sticky = |(s.frac & mask);
`else
        stage.sticky = 1'b0;
`endif
    end

endmodule

// File: rtl/fpu_adder16.sv
// FP16 unnormalized adder, 2-stage valid/ready pipeline (S1 align, S2 add).
// Output {sum, C} feeds fpuNormalizer16. Optional sticky output: FPU_ADD_STICKY_EN.
module fpu_adder16
    import fpu_adder16_pkg::*;
(
    input  logic  clock,
    input  logic  reset_n,
    input  logic  in_valid,
    output logic  in_ready,
    input  fp16_t a,
    input  fp16_t b,
    input  logic  sub,
    output logic  out_valid,
    input  logic  out_ready,
    output fp16_t sum,
    output logic  C
`ifdef FPU_ADD_STICKY_EN
    ,
    output logic  sticky
`endif
);

    fpAdd16Stage_t align_stage;
    fpAdd16Stage_t s1_d, s1_q;
    logic          s1_valid_d, s1_valid_q;
    logic          s2_valid_d, s2_valid_q;
    fp16_t         sum_d, sum_q;
    logic          c_d, c_q;
`ifdef FPU_ADD_STICKY_EN
    logic          sticky_d, sticky_q;
`endif
    logic          s1_adv, s2_adv;
    logic [FRACW:0] add_res;
    fp16_t         s2_sum;
    logic          s2_c;

    fpu_align16 u_align (
        .a     (a),
        .b     (b),
        .sub   (sub),
        .stage (align_stage)
    );

    // Stage advance: a stage moves when empty or when its successor moves.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
    end

    // S2 significand add/subtract; exact cancellation collapses to +0.
    always_comb begin
        if (s1_q.eff_sub) begin
            add_res = {1'b0, s1_q.l.frac - s1_q.s_shift};
        end else begin
            add_res = {1'b0, s1_q.l.frac} + {1'b0, s1_q.s_shift};
        end
        s2_sum      = s1_q.l;
        s2_sum.frac = add_res[FRACW-1:0];
        s2_c        = add_res[FRACW];
        if (s1_q.eff_sub && (add_res[FRACW-1:0] == '0)) begin
            s2_sum = '0;
            s2_c   = 1'b0;
        end
    end

    // Next-state for both pipeline registers; data only loads alongside valid.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        c_d        = c_q;
`ifdef FPU_ADD_STICKY_EN
        sticky_d   = sticky_q;
`endif
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d = align_stage;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d = s2_sum;
                c_d   = s2_c;
`ifdef FPU_ADD_STICKY_EN
                sticky_d = s1_q.sticky;
`endif
            end
        end
    end

    // Pipeline registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            c_q        <= 1'b0;
`ifdef FPU_ADD_STICKY_EN
            sticky_q   <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            c_q        <= c_d;
`ifdef FPU_ADD_STICKY_EN
            sticky_q   <= sticky_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign C         = c_q;
`ifdef FPU_ADD_STICKY_EN
    assign sticky    = sticky_q;
`endif

endmodule

// File: tb/tb_fpu_adder16.sv
// Directed self-checking bench for fpu_adder16 (sticky checked when FPU_ADD_STICKY_EN).
module tb_fpu_adder16;
    import fpu_adder16_pkg::*;

    logic  clock = 1'b0;
    logic  reset_n;
    logic  in_valid;
    logic  in_ready;
    fp16_t a;
    fp16_t b;
    logic  sub;
    logic  out_valid;
    logic  out_ready;
    fp16_t sum;
    logic  C;
`ifdef FPU_ADD_STICKY_EN
    logic  sticky;
`endif

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    fpu_adder16 dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .C         (C)
`ifdef FPU_ADD_STICKY_EN
        ,
        .sticky    (sticky)
`endif
    );

    always #5 clock = ~clock;

    function automatic fp16_t mk(input logic s, input logic [4:0] e, input logic [9:0] f);
        return {s, e, f};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_sticky(input string tag, input logic est);
`ifdef FPU_ADD_STICKY_EN
        chk({tag, "_sticky"}, 16'(sticky), 16'(est));
`endif
    endtask

    // Called at a negedge; transfers on the next posedge, result checked two edges later.
    task automatic run_op(input string tag, input fp16_t ta, input fp16_t tbv, input logic ts,
                          input fp16_t esum, input logic ec, input logic est);
        a         = ta;
        b         = tbv;
        sub       = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, 16'(in_ready), 16'd1);
        @(negedge clock);
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 16'(out_valid), 16'd0);
        @(negedge clock);
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_C"}, 16'(C), 16'(ec));
        chk_sticky(tag, est);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        #12;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_C", 16'(C), 16'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("add_carry", mk(0, 15, 10'h200), mk(0, 15, 10'h200), 1'b0, mk(0, 15, 10'h000), 1'b1, 1'b0);
        run_op("cancel",    mk(0, 15, 10'h200), mk(0, 15, 10'h200), 1'b1, 16'h0000,           1'b0, 1'b0);
        run_op("align",     mk(0, 16, 10'h200), mk(0, 15, 10'h201), 1'b0, mk(0, 16, 10'h300), 1'b0, 1'b1);
        run_op("large_d",   mk(1, 20, 10'h155), mk(0, 5, 10'h3FF),  1'b0, mk(1, 20, 10'h155), 1'b0, 1'b1);
        run_op("swap",      mk(0, 10, 10'h100), mk(0, 12, 10'h300), 1'b1, mk(1, 12, 10'h2C0), 1'b0, 1'b0);
        run_op("d_eq_10",   mk(0, 20, 10'h001), mk(0, 10, 10'h3FF), 1'b0, mk(0, 20, 10'h001), 1'b0, 1'b1);
        run_op("sub_neg_b", mk(0, 15, 10'h300), mk(1, 15, 10'h100), 1'b1, mk(0, 15, 10'h000), 1'b1, 1'b0);

        // Back-to-back stream with out_ready high: one result per cycle.
        a = mk(0, 15, 10'h200); b = mk(0, 15, 10'h200); sub = 1'b0; in_valid = 1'b1;
        @(negedge clock);
        a = mk(1, 20, 10'h155); b = mk(0, 5, 10'h3FF); sub = 1'b0;
        @(negedge clock);
        a = mk(0, 10, 10'h100); b = mk(0, 12, 10'h300); sub = 1'b1;
        chk("stream_valid1", 16'(out_valid), 16'd1);
        chk("stream_sum1", sum, mk(0, 15, 10'h000));
        chk("stream_C1", 16'(C), 16'd1);
        @(negedge clock);
        in_valid = 1'b0;
        chk("stream_valid2", 16'(out_valid), 16'd1);
        chk("stream_sum2", sum, mk(1, 20, 10'h155));
        @(negedge clock);
        chk("stream_valid3", 16'(out_valid), 16'd1);
        chk("stream_sum3", sum, mk(1, 12, 10'h2C0));
        @(negedge clock);
        chk("stream_drained", 16'(out_valid), 16'd0);

        // Backpressure: two accepted, third blocked, output held.
        out_ready = 1'b0;
        a = mk(0, 16, 10'h200); b = mk(0, 15, 10'h201); sub = 1'b0; in_valid = 1'b1;
        chk("bp_rdy1", 16'(in_ready), 16'd1);
        @(negedge clock);
        a = mk(0, 10, 10'h100); b = mk(0, 12, 10'h300); sub = 1'b1;
        chk("bp_rdy2", 16'(in_ready), 16'd1);
        @(negedge clock);
        a = mk(1, 20, 10'h155); b = mk(0, 5, 10'h3FF); sub = 1'b0;
        chk("bp_rdy3", 16'(in_ready), 16'd0);
        chk("bp_valid", 16'(out_valid), 16'd1);
        chk("bp_sum", sum, mk(0, 16, 10'h300));
        @(negedge clock);
        chk("bp_rdy4", 16'(in_ready), 16'd0);
        chk("bp_hold_valid", 16'(out_valid), 16'd1);
        chk("bp_hold_sum", sum, mk(0, 16, 10'h300));
        chk("bp_hold_C", 16'(C), 16'd0);

        // Asynchronous reset in the middle of the stall.
        #2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
        chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
        chk("mid_rst_sum", sum, 16'h0000);
        chk("mid_rst_C", 16'(C), 16'd0);
        chk_sticky("mid_rst", 1'b0);
        @(negedge clock);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        run_op("post_rst", mk(0, 16, 10'h200), mk(0, 15, 10'h201), 1'b0, mk(0, 16, 10'h300), 1'b0, 1'b1);
        @(negedge clock);
        chk("post_rst_drained", 16'(out_valid), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
